cv32e40p_fault_monitor: RTL
===========================

CV32E40P_FAULT_MONITOR -- requirements
Module: cv32e40p_fault_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of independent error channels (legal range 1..32).
REQ-002 SHALL have parameter CNT_W, default 8, per-channel counter width (legal range 2..16).
REQ-003 SHALL have parameter THRESH, default 4, alarm threshold count (legal range 1..2^CNT_W-1).
REQ-004 SHALL define IDX_W = max(1, clog2(NUM_CH)).
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit, reset; synchronous and active-low.
REQ-007 SHALL have port en_i, input, 1 bit, global count enable.
REQ-008 SHALL have port err_i, input, NUM_CH bits, per-channel error pulse, one event per cycle high.
REQ-009 SHALL have port mask_i, input, NUM_CH bits, 1 = channel ignored.
REQ-010 SHALL have port clr_req_i, input, 1 bit, clear request.
REQ-011 SHALL have port clr_mask_i, input, NUM_CH bits, channels to clear.
REQ-012 SHALL have port clr_ack_o, output, 1 bit, clear acknowledge.
REQ-013 SHALL have port rd_ch_i, input, IDX_W bits, counter read select.
REQ-014 SHALL have port rd_cnt_o, output, CNT_W bits, registered read data.
REQ-015 SHALL have port sticky_o, output, NUM_CH bits, sticky per-channel error flags.
REQ-016 SHALL have port first_valid_o, output, 1 bit, first-error capture valid.
REQ-017 SHALL have port first_ch_o, output, IDX_W bits, index of first channel in error.
REQ-018 SHALL have port irq_o, output, 1 bit, threshold alarm.
REQ-019 SHALL have port irq_ack_i, input, 1 bit, alarm acknowledge.

Function
REQ-020 SHALL define a counted event on channel c in a cycle as en_i=1 and err_i[c]=1 and mask_i[c]=0.
REQ-021 SHALL increment cnt[c] by 1 per counted event, saturating at 2^CNT_W-1 with no wrap.
REQ-022 SHALL set sticky[c] on the cycle after the first counted event; it stays set until cleared; sticky_o = sticky.
REQ-023 SHALL, when first_valid=0 and at least one counted event occurs, load first_ch with the lowest counted index and set first_valid; later events SHALL NOT alter it.
REQ-024 SHALL, on clr_req_i=1, clear cnt[c] and sticky[c] for every c with clr_mask_i[c]=1, and pulse clr_ack_o high for exactly the following cycle.
REQ-025 SHALL, on a clear, reset first_valid only when clr_mask_i covers every channel.
REQ-026 SHALL, on a counted event and a clear of the same channel in the same cycle, load cnt[c]=1 and sticky[c]=1; the clear loses only for that event.
REQ-027 SHALL ignore clr_req_i while clr_ack_o=1; requests are single-cycle and not queued.
REQ-028 SHALL register rd_cnt_o = cnt[rd_ch_i] with 1-cycle latency, reflecting cnt after that edge's update; rd_ch_i >= NUM_CH SHALL read 0.
REQ-029 SHALL define over = OR over c of (cnt[c] >= THRESH).
REQ-030 SHALL implement an alarm FSM with states IDLE, ALARM and HOLD.
REQ-031 SHALL move IDLE->ALARM on the cycle after over becomes 1.
REQ-032 SHALL move ALARM->HOLD on irq_ack_i=1.
REQ-033 SHALL move HOLD->IDLE when over=0.
REQ-034 SHALL move HOLD->ALARM if over is still 1 and a new counted event occurs on a channel with cnt >= THRESH-1.
REQ-035 SHALL drive irq_o=1 only in state ALARM.
REQ-036 SHALL ignore irq_ack_i in states IDLE and HOLD.
REQ-037 SHALL, in ALARM, move to IDLE when over=0 (all offending channels cleared) and SHALL NOT move there on irq_ack_i alone.

Reset
REQ-038 SHALL, on rst_ni=0 at a clock edge, set all cnt=0, sticky_o=0, first_valid_o=0, first_ch_o=0, rd_cnt_o=0, clr_ack_o=0, irq_o=0 and FSM=IDLE.
REQ-039 SHALL give reset precedence over all inputs, including mid-clear and mid-alarm.
REQ-040 SHALL count nothing in a cycle where rst_ni=0.

Verification
REQ-041 Bench SHALL cover: channel 2 has 4 error pulses with defaults -> rd_cnt_o(ch2)=4; irq_o rises the cycle after cnt reaches 4; sticky_o=5'b00100.
REQ-042 Bench SHALL cover: err_i=5'b10110 in one cycle from clean -> first_ch_o=1, first_valid_o=1; a later err_i[0] does not change first_ch_o.
REQ-043 Bench SHALL cover: CNT_W=2 with 5 pulses on ch0 -> cnt stays 3, no wrap.
REQ-044 Bench SHALL cover: clear of ch3 at cnt=6 while err_i[3]=1 -> cnt[3]=1, clr_ack_o high for exactly 1 cycle.
REQ-045 Bench SHALL cover: irq_ack_i in ALARM -> irq_o=0 (HOLD); clear all -> IDLE; a second irq_ack_i has no effect.
REQ-046 Bench SHALL cover: mask_i[1]=1 or en_i=0 with err_i[1] pulses -> cnt[1]=0; rst_ni=0 mid-alarm -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/cv32e40p_fault_monitor.sv
// Fault monitor: per-channel saturating error counters, sticky flags,
// first-error capture, clear handshake, registered counter readback and
// a threshold alarm with acknowledge/hold behaviour.
module cv32e40p_fault_monitor #(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 8,
    parameter int THRESH = 4,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] err_i,
    input  logic [NUM_CH-1:0] mask_i,
    input  logic              clr_req_i,
    input  logic [NUM_CH-1:0] clr_mask_i,
    output logic              clr_ack_o,
    input  logic [IDX_W-1:0]  rd_ch_i,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [NUM_CH-1:0] sticky_o,
    output logic              first_valid_o,
    output logic [IDX_W-1:0]  first_ch_o,
    output logic              irq_o,
    input  logic              irq_ack_i
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] THRESH_V  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);

    typedef enum logic [1:0] {IDLE, ALARM, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg  [NUM_CH];
    logic [CNT_W-1:0]   cnt_next [NUM_CH];
    logic [CNT_W-1:0]   cnt_inc  [NUM_CH];
    logic [NUM_CH-1:0]  sticky_reg, sticky_next;
    logic [NUM_CH-1:0]  counted, clr_ch, over_vec, hit_vec;
    logic               first_valid_reg, first_valid_next;
    logic [IDX_W-1:0]   first_ch_reg, first_ch_next;
    logic               clr_ack_reg;
    logic [CNT_W-1:0]   rd_cnt_reg, rd_cnt_next;
    logic               clr_go, clr_all, any_counted, over, hit;
    logic [IDX_W-1:0]   low_idx;

    // A request arriving while the previous acknowledge is still high is dropped.
    assign clr_go  = clr_req_i & ~clr_ack_reg;
    assign clr_all = clr_go & (&clr_mask_i);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign counted[gi]  = en_i & err_i[gi] & ~mask_i[gi];
            assign clr_ch[gi]   = clr_go & clr_mask_i[gi];
            assign cnt_inc[gi]  = (cnt_reg[gi] == CNT_MAX) ? cnt_reg[gi] : cnt_reg[gi] + CNT_ONE;
            // A same-cycle event survives a clear of its channel as a count of one.
            assign cnt_next[gi] = clr_ch[gi] ? (counted[gi] ? CNT_ONE : '0)
                                             : (counted[gi] ? cnt_inc[gi] : cnt_reg[gi]);
            assign sticky_next[gi] = clr_ch[gi] ? counted[gi] : (sticky_reg[gi] | counted[gi]);
            assign over_vec[gi] = (cnt_reg[gi] >= THRESH_V);
            assign hit_vec[gi]  = counted[gi] & (cnt_reg[gi] >= THRESH_M1);
        end
    endgenerate

    assign over = |over_vec;
    assign hit  = |hit_vec;

    // Lowest-index counted channel this cycle, for first-error capture.
    always_comb begin
        low_idx     = '0;
        any_counted = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (counted[c]) begin
                low_idx     = IDX_W'(c);
                any_counted = 1'b1;
            end
        end
    end

    // First-error capture: a full clear re-arms it, and an event in that same cycle re-captures.
    always_comb begin
        first_valid_next = first_valid_reg;
        first_ch_next    = first_ch_reg;
        if (clr_all) begin
            first_valid_next = 1'b0;
            first_ch_next    = '0;
        end
        if ((!first_valid_reg || clr_all) && any_counted) begin
            first_valid_next = 1'b1;
            first_ch_next    = low_idx;
        end
    end

    // Readback shows the counter value as updated by this edge; out-of-range reads give 0.
    always_comb begin
        rd_cnt_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch_i == IDX_W'(c)) rd_cnt_next = cnt_next[c];
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) cnt_reg[c] <= '0;
            sticky_reg      <= '0;
            first_valid_reg <= 1'b0;
            first_ch_reg    <= '0;
            clr_ack_reg     <= 1'b0;
            rd_cnt_reg      <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) cnt_reg[c] <= cnt_next[c];
            sticky_reg      <= sticky_next;
            first_valid_reg <= first_valid_next;
            first_ch_reg    <= first_ch_next;
            clr_ack_reg     <= clr_go;
            rd_cnt_reg      <= rd_cnt_next;
        end
    end

    // Alarm FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    // Alarm FSM next state; leaving ALARM for IDLE needs all offenders cleared.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (over) state_next = ALARM;
            ALARM: begin
                if (!over)          state_next = IDLE;
                else if (irq_ack_i) state_next = HOLD;
            end
            HOLD: begin
                if (!over)    state_next = IDLE;
                else if (hit) state_next = ALARM;
            end
            default: state_next = IDLE;
        endcase
    end

    // Alarm FSM outputs.
    always_comb begin
        irq_o = (state_reg == ALARM);
    end

    assign clr_ack_o     = clr_ack_reg;
    assign rd_cnt_o      = rd_cnt_reg;
    assign sticky_o      = sticky_reg;
    assign first_valid_o = first_valid_reg;
    assign first_ch_o    = first_ch_reg;

endmodule
